// File: rtl/control_r_if.sv
// Decoder bus: instruction word in, registered control fields out.
// illegal_inst exists only when CONTROL_R_ILLEGAL_CHK_EN is defined.
interface control_r_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] instruction_word;
  logic [3:0]      alu_ctrl;
  logic            shamt_en;
  logic [2:0]      branch_ctrl;
  logic            reg_write;
  logic [2:0]      inst_type;
`ifdef CONTROL_R_ILLEGAL_CHK_EN
  logic            illegal_inst;
`endif

  // Fetch side drives the instruction word and consumes the decode.
  modport master (
    output instruction_word,
    input  alu_ctrl, shamt_en, branch_ctrl, reg_write, inst_type
`ifdef CONTROL_R_ILLEGAL_CHK_EN
    , input illegal_inst
`endif
  );

  modport slave (
    input  instruction_word,
    output alu_ctrl, shamt_en, branch_ctrl, reg_write, inst_type
`ifdef CONTROL_R_ILLEGAL_CHK_EN
    , output illegal_inst
`endif
  );
endinterface

// File: rtl/control_r.sv
// Registered RV32I main decoder: opcode/funct3/funct7 -> class, ALU op, branch cond, rd write.
// Latency one cycle; no backpressure (free-running, every cycle sampled).
// Optional CONTROL_R_ILLEGAL_CHK_EN adds illegal_inst and full funct7 checking.
module control_r #(
  parameter int XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  control_r_if.slave  dec
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLT  = 3'd3,
    BR_BGE  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BGEU = 3'd6,
    BR_JUMP = 3'd7
  } br_cond_e;

  typedef enum logic [2:0] {
    TYPE_R       = 3'd0,
    TYPE_I       = 3'd1,
    TYPE_S       = 3'd2,
    TYPE_B       = 3'd3,
    TYPE_U       = 3'd4,
    TYPE_J       = 3'd5,
    TYPE_INVALID = 3'd7
  } inst_type_e;

  typedef struct packed {
    inst_type_e inst_type;
    alu_op_e    alu_ctrl;
    br_cond_e   branch_ctrl;
    logic       shamt_en;
    logic       reg_write;
  } dec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam dec_t RESET_DEC = '{
    inst_type:   TYPE_INVALID,
    alu_ctrl:    ALU_ADD,
    branch_ctrl: BR_NONE,
    shamt_en:    1'b0,
    reg_write:   1'b0
  };

  // funct3 -> ALU op; alt selects SUB/SRA on the two funct3 codes that have one.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [XLEN-1:0] insn;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            bit30;
  logic            unused_insn;

  assign insn        = dec.instruction_word;
  assign opcode      = insn[6:0];
  assign funct3      = insn[14:12];
  assign bit30       = insn[30];
  assign unused_insn = ^{insn[31], insn[29:15], insn[11:7]};

  dec_t dec_raw;
  dec_t dec_nxt;
  dec_t dec_q;

  always_comb begin
    dec_raw = RESET_DEC;
    case (opcode)
      OP_R: begin
        dec_raw.inst_type = TYPE_R;
        dec_raw.reg_write = 1'b1;
        dec_raw.alu_ctrl  = alu_from_f3(funct3, bit30);
      end
      OP_LOAD: begin
        dec_raw.inst_type = TYPE_I;
        dec_raw.reg_write = 1'b1;
      end
      OP_IMM: begin
        // addi has no subtract form: bit30 there is immediate data.
        dec_raw.inst_type = TYPE_I;
        dec_raw.reg_write = 1'b1;
        dec_raw.alu_ctrl  = alu_from_f3(funct3, (funct3 == 3'b000) ? 1'b0 : bit30);
        dec_raw.shamt_en  = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      OP_JALR: begin
        dec_raw.inst_type   = TYPE_I;
        dec_raw.branch_ctrl = BR_JUMP;
        dec_raw.reg_write   = 1'b1;
      end
      OP_STORE: begin
        dec_raw.inst_type = TYPE_S;
      end
      OP_BRANCH: begin
        dec_raw.inst_type = TYPE_B;
        dec_raw.alu_ctrl  = ALU_SUB;
        case (funct3)
          3'b000:  dec_raw.branch_ctrl = BR_BEQ;
          3'b001:  dec_raw.branch_ctrl = BR_BNE;
          3'b100:  dec_raw.branch_ctrl = BR_BLT;
          3'b101:  dec_raw.branch_ctrl = BR_BGE;
          3'b110:  dec_raw.branch_ctrl = BR_BLTU;
          3'b111:  dec_raw.branch_ctrl = BR_BGEU;
          default: begin
            dec_raw.branch_ctrl = BR_NONE;
            dec_raw.inst_type   = TYPE_INVALID;
          end
        endcase
      end
      OP_LUI: begin
        dec_raw.inst_type = TYPE_U;
        dec_raw.alu_ctrl  = ALU_PASSB;
        dec_raw.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        dec_raw.inst_type = TYPE_U;
        dec_raw.reg_write = 1'b1;
      end
      OP_JAL: begin
        dec_raw.inst_type   = TYPE_J;
        dec_raw.branch_ctrl = BR_JUMP;
        dec_raw.reg_write   = 1'b1;
      end
      default: dec_raw = RESET_DEC;
    endcase
  end

`ifdef CONTROL_R_ILLEGAL_CHK_EN
  logic [6:0] funct7;
  logic       r_f7_bad;
  logic       shift_f7_bad;
  logic       illegal_nxt;
  logic       illegal_q;

  assign funct7 = insn[31:25];

  // The alternate funct7 encoding only exists for sub and sra.
  always_comb begin
    r_f7_bad = 1'b0;
    if (opcode == OP_R) begin
      if (funct7 == 7'b0100000)
        r_f7_bad = (funct3 != 3'b000) && (funct3 != 3'b101);
      else
        r_f7_bad = (funct7 != 7'b0000000);
    end
  end

  always_comb begin
    shift_f7_bad = 1'b0;
    if (opcode == OP_IMM) begin
      if (funct3 == 3'b001)
        shift_f7_bad = (funct7 != 7'b0000000);
      else if (funct3 == 3'b101)
        shift_f7_bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
    end
  end

  always_comb begin
    dec_nxt     = dec_raw;
    illegal_nxt = (dec_raw.inst_type == TYPE_INVALID) || r_f7_bad || shift_f7_bad;
    if (illegal_nxt) begin
      dec_nxt.reg_write   = 1'b0;
      dec_nxt.branch_ctrl = BR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_q <= 1'b0;
    else
      illegal_q <= illegal_nxt;
  end

  assign dec.illegal_inst = illegal_q;
`else
  always_comb begin
    dec_nxt = dec_raw;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dec_q <= RESET_DEC;
    else
      dec_q <= dec_nxt;
  end

  assign dec.inst_type   = dec_q.inst_type;
  assign dec.alu_ctrl    = dec_q.alu_ctrl;
  assign dec.branch_ctrl = dec_q.branch_ctrl;
  assign dec.shamt_en    = dec_q.shamt_en;
  assign dec.reg_write   = dec_q.reg_write;

endmodule

// File: tb/tb_control_r.sv
// Directed bench for control_r: reset behaviour, per-class decode, one-edge lag, async reset.
module tb_control_r;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  control_r_if #(.XLEN(32)) bus ();

  control_r #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dec   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] insn;
    logic [2:0]  typ;
    logic [3:0]  alu;
    logic [2:0]  br;
    logic        sh;
    logic        rw;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  task automatic add_vec(input string name, input logic [31:0] insn, input logic [2:0] typ,
                         input logic [3:0] alu, input logic [2:0] br, input logic sh,
                         input logic rw, input logic ill);
    vec_t v;
    v.name = name; v.insn = insn; v.typ = typ; v.alu = alu;
    v.br = br; v.sh = sh; v.rw = rw; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, "/", v.name, ".inst_type"},   {29'd0, bus.inst_type},   {29'd0, v.typ});
    check({tag, "/", v.name, ".alu_ctrl"},    {28'd0, bus.alu_ctrl},    {28'd0, v.alu});
    check({tag, "/", v.name, ".branch_ctrl"}, {29'd0, bus.branch_ctrl}, {29'd0, v.br});
    check({tag, "/", v.name, ".shamt_en"},    {31'd0, bus.shamt_en},    {31'd0, v.sh});
    check({tag, "/", v.name, ".reg_write"},   {31'd0, bus.reg_write},   {31'd0, v.rw});
`ifdef CONTROL_R_ILLEGAL_CHK_EN
    check({tag, "/", v.name, ".illegal"},     {31'd0, bus.illegal_inst}, {31'd0, v.ill});
`endif
  endtask

  task automatic check_reset(input string tag);
    vec_t r;
    r.name = "rst"; r.insn = 32'd0; r.typ = 3'd7; r.alu = 4'd0;
    r.br = 3'd0; r.sh = 1'b0; r.rw = 1'b0; r.ill = 1'b0;
    check_vec(tag, r);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;

    //       name        insn           typ  alu    br   sh    rw    ill
    add_vec("add",      32'h0049_82B3, 3'd0, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("sub",      32'h4059_8333, 3'd0, 4'd1,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("sll",      32'h0049_92B3, 3'd0, 4'd2,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("sra",      32'h4000_5033, 3'd0, 4'd7,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("and",      32'h0000_7033, 3'd0, 4'd9,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("lb",       32'h2099_8383, 3'd1, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("load101",  32'h0000_5003, 3'd1, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("srai",     32'h4031_5093, 3'd1, 4'd7,  3'd0, 1'b1, 1'b1, 1'b0);
    add_vec("slli",     32'h0031_1093, 3'd1, 4'd2,  3'd0, 1'b1, 1'b1, 1'b0);
    add_vec("addi_b30", 32'h4000_0013, 3'd1, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("slti",     32'h0000_2013, 3'd1, 4'd3,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("jalr",     32'h0000_0067, 3'd1, 4'd0,  3'd7, 1'b0, 1'b1, 1'b0);
    add_vec("sw",       32'h0F56_A6A3, 3'd2, 4'd0,  3'd0, 1'b0, 1'b0, 1'b0);
    add_vec("bgeu",     32'h0F56_F6E3, 3'd3, 4'd1,  3'd6, 1'b0, 1'b0, 1'b0);
    add_vec("blt",      32'h0F56_C6E3, 3'd3, 4'd1,  3'd3, 1'b0, 1'b0, 1'b0);
    add_vec("beq",      32'h0000_0063, 3'd3, 4'd1,  3'd1, 1'b0, 1'b0, 1'b0);
    add_vec("br010",    32'h0000_2063, 3'd7, 4'd1,  3'd0, 1'b0, 1'b0, 1'b1);
    add_vec("lui",      32'h0F56_B6B7, 3'd4, 4'd10, 3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("auipc",    32'h0000_0017, 3'd4, 4'd0,  3'd0, 1'b0, 1'b1, 1'b0);
    add_vec("jal",      32'h0000_006F, 3'd5, 4'd0,  3'd7, 1'b0, 1'b1, 1'b0);
    add_vec("op7f",     32'h0000_007F, 3'd7, 4'd0,  3'd0, 1'b0, 1'b0, 1'b1);

    // Reset held across edges with a valid instruction present.
    rst_n = 1'b0;
    bus.instruction_word = 32'h0049_82B3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("reset_hold");

    rst_n = 1'b1;
    // New instruction every cycle: before the edge the previous decode must still show.
    for (int i = 0; i < vecs.size(); i++) begin
      bus.instruction_word = vecs[i].insn;
      #1;
      if (i == 0)
        check_reset("pre_edge");
      else
        check_vec("lag", vecs[i-1]);
      @(posedge clk);
      #1;
      check_vec("dec", vecs[i]);
      @(negedge clk);
    end

    // Asynchronous reset in mid-cycle, away from any clock edge.
    bus.instruction_word = 32'h0F56_B6B7;
    @(posedge clk);
    #1;
    check("pre_async.reg_write", {31'd0, bus.reg_write}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    @(posedge clk);
    #1;
    check_reset("async_hold");
    @(negedge clk);
    rst_n = 1'b1;
    bus.instruction_word = 32'h0000_006F;
    @(posedge clk);
    #1;
    check_vec("post_rst", vecs[vecs.size()-2]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
